// File: rtl/memory_sram_slave_if.sv
// memory_if: request/response bus between a memory master and a memory slave.
// Writes and reads each have their own enable, address and done strobe.
interface memory_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_byteen;
  logic                    wr_done;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic                    rd_done;
  logic [DATA_WIDTH-1:0]   rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, wr_byteen,
    input  wr_done,
    output rd_en, rd_addr,
    input  rd_done, rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_byteen,
    output wr_done,
    input  rd_en, rd_addr,
    output rd_done, rd_data
  );
endinterface

// File: rtl/memory_sram_slave.sv
// memory_sram_slave: single-port register-array RAM answering memory_if requests.
// One operation at a time; write/read each complete after a fixed latency and
// are acknowledged with a one-cycle done pulse. Simultaneous requests are
// granted alternately, starting with the write.
module memory_sram_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int WR_LATENCY = 1,
  parameter int RD_LATENCY = 2
) (
  input logic     clk_i,
  input logic     rst_i,
  memory_if.slave s_mem
);

  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int OFF_W   = $clog2(BYTES);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int MAX_LAT = (WR_LATENCY > RD_LATENCY) ? WR_LATENCY : RD_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WR_BUSY = 2'd1;
  localparam logic [1:0] ST_RD_BUSY = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic [1:0]            state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  last_grant_r;
  logic [IDX_W-1:0]      idx_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic [BYTES-1:0]      byteen_r;
  logic                  wr_done_r;
  logic                  rd_done_r;
  logic [DATA_WIDTH-1:0] rd_data_r;

  logic                  accept_s;
  logic                  grant_wr_s;
  logic [IDX_W-1:0]      wr_idx_in_s;
  logic [IDX_W-1:0]      rd_idx_in_s;
  logic                  wr_commit_s;
  logic                  rd_commit_s;
  logic [IDX_W-1:0]      commit_idx_s;
  logic [DATA_WIDTH-1:0] commit_data_s;
  logic [BYTES-1:0]      commit_be_s;

  assign s_mem.wr_done = wr_done_r;
  assign s_mem.rd_done = rd_done_r;
  assign s_mem.rd_data = rd_data_r;

  // Decode word indices, arbitrate, and decide whether this edge commits an op.
  always_comb begin
    wr_idx_in_s   = IDX_W'(s_mem.wr_addr >> OFF_W);
    rd_idx_in_s   = IDX_W'(s_mem.rd_addr >> OFF_W);
    accept_s      = (state_r == ST_IDLE) && (s_mem.wr_en || s_mem.rd_en) && !rst_i;
    grant_wr_s    = s_mem.wr_en && (!s_mem.rd_en || (last_grant_r == GRANT_RD));
    wr_commit_s   = 1'b0;
    rd_commit_s   = 1'b0;
    commit_idx_s  = idx_r;
    commit_data_s = wdata_r;
    commit_be_s   = byteen_r;
    case (state_r)
      ST_IDLE: begin
        // Single-cycle latency commits straight from the bus on the accept edge.
        if (accept_s && grant_wr_s && (WR_LATENCY == 1)) begin
          wr_commit_s   = 1'b1;
          commit_idx_s  = wr_idx_in_s;
          commit_data_s = s_mem.wr_data;
          commit_be_s   = s_mem.wr_byteen;
        end else if (accept_s && !grant_wr_s && (RD_LATENCY == 1)) begin
          rd_commit_s  = 1'b1;
          commit_idx_s = rd_idx_in_s;
        end else begin
          wr_commit_s = 1'b0;
          rd_commit_s = 1'b0;
        end
      end
      ST_WR_BUSY: begin
        if (cnt_r == CNT_W'(1)) begin
          wr_commit_s = 1'b1;
        end else begin
          wr_commit_s = 1'b0;
        end
      end
      ST_RD_BUSY: begin
        if (cnt_r == CNT_W'(1)) begin
          rd_commit_s = 1'b1;
        end else begin
          rd_commit_s = 1'b0;
        end
      end
      default: begin
        wr_commit_s = 1'b0;
        rd_commit_s = 1'b0;
      end
    endcase
  end

  // Control FSM, request capture, done strobes and read data register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      last_grant_r <= GRANT_RD;
      idx_r        <= '0;
      wdata_r      <= '0;
      byteen_r     <= '0;
      wr_done_r    <= 1'b0;
      rd_done_r    <= 1'b0;
      rd_data_r    <= '0;
    end else begin
      wr_done_r <= wr_commit_s;
      rd_done_r <= rd_commit_s;
      if (rd_commit_s) begin
        rd_data_r <= mem_r[commit_idx_s];
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (grant_wr_s) begin
              last_grant_r <= GRANT_WR;
              idx_r        <= wr_idx_in_s;
              wdata_r      <= s_mem.wr_data;
              byteen_r     <= s_mem.wr_byteen;
              cnt_r        <= CNT_W'(WR_LATENCY - 1);
              state_r      <= (WR_LATENCY == 1) ? ST_DONE : ST_WR_BUSY;
            end else begin
              last_grant_r <= GRANT_RD;
              idx_r        <= rd_idx_in_s;
              cnt_r        <= CNT_W'(RD_LATENCY - 1);
              state_r      <= (RD_LATENCY == 1) ? ST_DONE : ST_RD_BUSY;
            end
          end
        end
        ST_WR_BUSY, ST_RD_BUSY: begin
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory array: byte-enabled write on the commit edge; deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_commit_s) begin
      for (int b = 0; b < BYTES; b++) begin
        if (commit_be_s[b]) begin
          mem_r[commit_idx_s][8*b +: 8] <= commit_data_s[8*b +: 8];
        end
      end
    end
  end

endmodule
